iob_2p_ram_fifo_ctrl: RTL
=========================

// Module: iob_2p_ram_fifo_ctrl
// PURPOSE
//  Synchronous FIFO controller that drives an external two-port RAM: one write port, one read port, 1-cycle registered read.
//  It turns the RAM into a first-word-fall-through stream FIFO with valid/ready on both sides.
//  It owns the pointers, occupancy and read prefetch. The RAM instance sits beside it in the parent module.
// PARAMETERS
//  DATA_W  32  stream and RAM word width in bits
//  ADDR_W  4   RAM address width; RAM depth DEPTH = 2**ADDR_W (ADDR_W >= 1)
// PORTS
//  clk         in   1         single clock, all state on posedge
//  rst_n       in   1         asynchronous, active-low reset
//  clr         in   1         synchronous flush, priority over push/pop
//  in_valid    in   1         producer has a word
//  in_data     in   DATA_W    producer word
//  in_ready    out  1         controller accepts in_data this cycle
//  out_valid   out  1         out_data holds the oldest word
//  out_data    out  DATA_W    oldest word, driven directly from ram_r_data
//  out_ready   in   1         consumer takes out_data this cycle
//  level       out  ADDR_W+1  total words held = ram_cnt + out_valid (0..DEPTH+1)
//  ram_w_en    out  1         RAM write enable
//  ram_w_addr  out  ADDR_W    RAM write address (= wr_ptr)
//  ram_w_data  out  DATA_W    RAM write data (= in_data)
//  ram_r_en    out  1         RAM read enable
//  ram_r_addr  out  ADDR_W    RAM read address (= rd_ptr)
//  ram_r_data  in   DATA_W    RAM read data; valid 1 cycle after ram_r_en, held while ram_r_en low
// BEHAVIOUR
//  State registers and reset values:
//   - wr_ptr, rd_ptr: ADDR_W bits, reset 0.
//   - ram_cnt: ADDR_W+1 bits, reset 0. Counts words written to the RAM and not yet read out.
//   - out_valid: reset 0.
//  Outputs during reset (rst_n low): in_ready=0, ram_w_en=0, ram_r_en=0, out_valid=0, level=0.
//  Push:
//   - in_ready = !clr && (ram_cnt != DEPTH).
//   - push = in_valid && in_ready.
//   - ram_w_en = push. On push, wr_ptr increments and wraps from DEPTH-1 to 0.
//  Pop:
//   - pop = out_valid && out_ready.
//   - out_data must not be consumed when out_valid=0.
//  Prefetch:
//   - ram_r_en = !clr && (ram_cnt != 0) && (!out_valid || out_ready).
//   - On ram_r_en, rd_ptr increments and wraps.
//   - Next cycle out_valid = ram_r_en. Otherwise out_valid = out_valid && !pop.
//  Count update:
//   - ram_cnt_next = ram_cnt + push - ram_r_en (push and read in the same cycle leave it unchanged).
//  Throughput and latency:
//   - Steady stream: one word per cycle each side.
//   - Latency into an empty FIFO: push at cycle t, ram_r_en at t+1, out_valid at t+2.
//   - out_data and out_valid stay stable while out_valid && !out_ready.
//  Boundary conditions:
//   - Full: in_ready=0 when ram_cnt==DEPTH, so level can reach DEPTH+1.
//   - Full, same cycle: a pop that cycle does not raise in_ready combinationally; in_ready rises the next cycle.
//   - Address collision: the controller never reads and writes the same address in one cycle.
//     Reads need ram_cnt>0; writes need ram_cnt<DEPTH.
//   - Empty: ram_cnt==0 means no read. A word pushed this cycle is not readable until the next cycle.
//   - clr: next cycle wr_ptr=rd_ptr=0, ram_cnt=0, out_valid=0. Any concurrent push or pop is discarded.
//   - Reset mid-stream: all state returns to reset values immediately. Contents are lost. RAM contents are don't-care.
// TESTING
//  1. Reset, then push 0xA0 once.
//     -> ram_w_en at t; ram_r_en (addr 0) at t+1; out_valid=1 with out_data=0xA0 at t+2; level 1.
//  2. DEPTH=16, out_ready=0, push 20 words.
//     -> 17 accepted (16 RAM + 1 out stage); level=17; in_ready=0; no write while full.
//  3. Then out_ready=1 continuously.
//     -> 17 words out in order, one per cycle; in_ready returns 1 the cycle after the first pop; level ends 0.
//  4. Continuous push and pop of 0..99 with out_ready=1.
//     -> output 0..99 in order, 1/cycle after 2-cycle fill; ptr wrap 15->0 verified; level stays <=2.
//  5. Random valid/ready backpressure, 1000 words.
//     -> scoreboard order exact; out_data stable while out_valid && !out_ready; no same-address read/write.
//  6. Level=5, assert clr with in_valid=1 and out_ready=1 in the same cycle.
//     -> next cycle level=0, out_valid=0, pointers 0; push dropped. Same check for rst_n low mid-stream.

Source files
------------

// File: rtl/iob_2p_ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external two-port RAM with a
// 1-cycle registered read port; owns pointers, occupancy and the output prefetch.
module iob_2p_ram_fifo_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   level,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_w_addr,
  output logic [DATA_W-1:0] ram_w_data,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_r_addr,
  input  logic [DATA_W-1:0] ram_r_data
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(1 << ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   ram_cnt;
  logic              push;

  // rst_n gates the handshakes so nothing is offered while reset is held.
  always_comb begin
    in_ready = rst_n && !clr && (ram_cnt != FULL_CNT);
    push     = in_valid && in_ready;
    ram_r_en = rst_n && !clr && (ram_cnt != '0) && (!out_valid || out_ready);
  end

  assign ram_w_en   = push;
  assign ram_w_addr = wr_ptr;
  assign ram_w_data = in_data;
  assign ram_r_addr = rd_ptr;
  assign out_data   = ram_r_data;
  assign level      = ram_cnt + {{ADDR_W{1'b0}}, out_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ADDR_W'(1);
      if (ram_r_en)
        rd_ptr <= rd_ptr + ADDR_W'(1);
      ram_cnt <= ram_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(ram_r_en);
      // A prefetch always refills the output stage; otherwise it drains on pop.
      if (ram_r_en)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
    end
  end

endmodule
